// File: rtl/qdivs.sv
// Sequential sign-magnitude Q-format divider: restoring division, one quotient bit per clock, MSB first.
// Optional build macro QDIV_SATURATE_EN saturates the magnitude on overflow instead of wrapping.
module qdivs #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  input  logic         i_start,
  output logic [N-1:0] o_quotient_out,
  output logic         o_complete,
  output logic         o_overflow,
  output logic         o_div_by_zero
);

  localparam int W  = N - 1 + Q;
  localparam int CW = $clog2(W + 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_DIVIDE = 1'b1;

  logic [0:0]    state_reg;
  logic [W-1:0]  dvd_reg;
  logic [W-2:0]  quo_reg;
  logic [N-2:0]  rem_reg;
  logic [N-2:0]  dsr_reg;
  logic [CW-1:0] cnt_reg;
  logic          sign_reg;
  logic [N-1:0]  q_reg;
  logic          ovf_reg;
  logic          dbz_reg;

  logic [N-1:0]  rem_shift;
  logic [N-2:0]  rem_next;
  logic [W-1:0]  quo_next;
  logic          take;
  logic          wrap_ovf;
  logic          dbz;
  logic [N-2:0]  mag_next;

  // The remainder is always below the divisor, so N-1 bits hold it; the
  // shifted value needs one extra bit only for the compare/subtract.
  always_comb begin
    rem_shift = {rem_reg, dvd_reg[W-1]};
    take      = rem_shift >= {1'b0, dsr_reg};
    rem_next  = take ? (N-1)'(rem_shift - {1'b0, dsr_reg}) : rem_shift[N-2:0];
    quo_next  = {quo_reg, take};
    wrap_ovf  = |quo_next[W-1:N-1];
    dbz       = (dsr_reg == '0);
`ifdef QDIV_SATURATE_EN
    mag_next  = wrap_ovf ? '1 : quo_next[N-2:0];
`else
    mag_next  = quo_next[N-2:0];
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      dvd_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dsr_reg   <= '0;
      cnt_reg   <= '0;
      sign_reg  <= 1'b0;
      q_reg     <= '0;
      ovf_reg   <= 1'b0;
      dbz_reg   <= 1'b0;
    end else if (state_reg == S_IDLE) begin
      if (i_start) begin
        dvd_reg   <= {i_dividend[N-2:0], {Q{1'b0}}};
        dsr_reg   <= i_divisor[N-2:0];
        sign_reg  <= i_dividend[N-1] ^ i_divisor[N-1];
        rem_reg   <= '0;
        quo_reg   <= '0;
        cnt_reg   <= CW'(W);
        state_reg <= S_DIVIDE;
      end
    end else begin
      if (dbz) begin
        q_reg     <= {sign_reg, {(N-1){1'b1}}};
        ovf_reg   <= 1'b1;
        dbz_reg   <= 1'b1;
        state_reg <= S_IDLE;
      end else begin
        rem_reg <= rem_next;
        quo_reg <= quo_next[W-2:0];
        dvd_reg <= {dvd_reg[W-2:0], 1'b0};
        cnt_reg <= cnt_reg - CW'(1);
        // Last iteration finalizes on the same edge, using the fresh quotient bit.
        if (cnt_reg == CW'(1)) begin
          q_reg     <= {sign_reg & (|mag_next), mag_next};
          ovf_reg   <= wrap_ovf;
          dbz_reg   <= 1'b0;
          state_reg <= S_IDLE;
        end
      end
    end
  end

  assign o_quotient_out = q_reg;
  assign o_complete     = (state_reg == S_IDLE);
  assign o_overflow     = ovf_reg;
  assign o_div_by_zero  = dbz_reg;

endmodule

// File: tb/tb_qdivs.sv
// Self-checking bench for qdivs: vector table plus scoreboard queue, with
// hand-written sequences for mid-division start pulses and reset abort.
module tb_qdivs;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        i_start;
  logic [31:0] o_quotient_out;
  logic        o_complete;
  logic        o_overflow;
  logic        o_div_by_zero;

  qdivs #(.Q(15), .N(32)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .i_start       (i_start),
    .o_quotient_out(o_quotient_out),
    .o_complete    (o_complete),
    .o_overflow    (o_overflow),
    .o_div_by_zero (o_div_by_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ovf;
    logic        dbz;
    int          busy;
    logic        disturb;
  } vec_t;

  vec_t        sb[$];
  vec_t        tbl[7];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] prev_q;
  logic        prev_ovf;
  logic        prev_dbz;

`ifdef QDIV_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division of the Q-scaled magnitudes.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
    vec_t        v;
    logic [45:0] num;
    logic [45:0] quo;
    logic [30:0] mag;
    v.a = a; v.b = b; v.disturb = 1'b0;
    num = {a[30:0], 15'b0};
    if (b[30:0] == 31'd0) begin
      mag = '1; v.ovf = 1'b1; v.dbz = 1'b1; v.busy = 1;
    end else begin
      quo   = num / {15'b0, b[30:0]};
      v.ovf = (quo >= 46'h0000_8000_0000);
      v.dbz = 1'b0;
      v.busy = 46;
      mag   = (v.ovf && SAT) ? 31'h7FFF_FFFF : quo[30:0];
    end
    v.q = {(a[31] ^ b[31]) && (mag != 31'd0), mag};
    return v;
  endfunction

  task automatic run_div(input vec_t v);
    int   busy;
    bit   hold_ok;
    vec_t e;
    @(negedge i_clk);
    i_dividend = v.a;
    i_divisor  = v.b;
    i_start    = 1'b1;
    sb.push_back(v);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", {31'b0, o_complete}, 32'd0);
    if (v.disturb) begin
      i_start    = 1'b1;
      i_dividend = 32'h1234_5678;
      i_divisor  = 32'h0000_0003;
    end
    busy = 0;
    hold_ok = 1'b1;
    while (busy < 200) begin
      @(posedge i_clk); #1;
      busy++;
      if (busy == 1) i_start = 1'b0;
      if (o_complete) break;
      if (o_quotient_out !== prev_q || o_overflow !== prev_ovf || o_div_by_zero !== prev_dbz)
        hold_ok = 1'b0;
    end
    i_start = 1'b0;
    e = sb.pop_front();
    $display("div %h / %h -> %h ovf=%b dbz=%b busy=%0d", e.a, e.b, o_quotient_out,
             o_overflow, o_div_by_zero, busy);
    chk("busy_cycles", busy, e.busy);
    chk("quotient", o_quotient_out, e.q);
    chk("overflow", {31'b0, o_overflow}, {31'b0, e.ovf});
    chk("div_by_zero", {31'b0, o_div_by_zero}, {31'b0, e.dbz});
    chk("hold_prev", {31'b0, hold_ok}, 32'd1);
    prev_q = e.q; prev_ovf = e.ovf; prev_dbz = e.dbz;
  endtask

  initial begin
    tbl[0] = '{32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0, 46, 1'b0};
    tbl[1] = '{32'h8000_8000, 32'h0002_0000, 32'h8000_2000, 1'b0, 1'b0, 46, 1'b0};
    tbl[2] = '{32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 1'b0, 46, 1'b0};
    tbl[3] = '{32'h0000_8000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h0000_8000, 32'h0000_0000, 1'b0, 1'b0, 46, 1'b0};
`ifdef QDIV_SATURATE_EN
    tbl[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 46, 1'b0};
`else
    tbl[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_8000, 1'b1, 1'b0, 46, 1'b0};
`endif
    tbl[6] = '{32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0, 46, 1'b1};

    // Reset with a simultaneous start: reset must win.
    i_rst = 1'b1; i_start = 1'b1;
    i_dividend = 32'h0001_8000; i_divisor = 32'h0001_0000;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_complete", {31'b0, o_complete}, 32'd1);
    chk("rst_quotient", o_quotient_out, 32'd0);
    chk("rst_overflow", {31'b0, o_overflow}, 32'd0);
    chk("rst_dbz", {31'b0, o_div_by_zero}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0; i_start = 1'b0;
    prev_q = 32'd0; prev_ovf = 1'b0; prev_dbz = 1'b0;

    for (int i = 0; i < 7; i++) run_div(tbl[i]);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h00FF_FFFF))};
      b = {1'($urandom_range(0, 1)), 31'($urandom_range(1, 32'h0007_FFFF))};
      run_div(model(a, b));
    end

    // Abort a division with reset, then confirm a clean restart.
    @(negedge i_clk);
    i_dividend = 32'h0000_8000; i_divisor = 32'h0001_8000; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (10) @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("abort_complete", {31'b0, o_complete}, 32'd1);
    chk("abort_quotient", o_quotient_out, 32'd0);
    chk("abort_overflow", {31'b0, o_overflow}, 32'd0);
    chk("abort_dbz", {31'b0, o_div_by_zero}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    prev_q = 32'd0; prev_ovf = 1'b0; prev_dbz = 1'b0;
    run_div(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
